kgp_regfile: RTL
================

# kgp_regfile

General-purpose register file for KGP-RISC: 32 × 32-bit registers with two combinational read ports, one synchronous write port, and a four-phase debug read port. Sits directly downstream of the 3:1 destination-register select mux, which drives `wr_addr` with rd, rt, or 31 for link writes. The register file feeds the ALU operand stage and the branch comparator.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width
- `CNT_W`, 16, width of the committed-write counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rs_addr`  in  ADDR_W  read port A address
- `rt_addr`  in  ADDR_W  read port B address
- `rs_data`  out  DATA_W  read port A data, combinational
- `rt_data`  out  DATA_W  read port B data, combinational
- `we`  in  1  write enable
- `wr_addr`  in  ADDR_W  write address from the destination select mux
- `wr_data`  in  DATA_W  write-back data
- `dbg_req`  in  1  debug read request, level, four-phase handshake
- `dbg_addr`  in  ADDR_W  debug read address; sampled when the request is accepted
- `dbg_ack`  out  1  debug acknowledge
- `dbg_data`  out  DATA_W  debug read data; valid while `dbg_ack`=1
- `wr_count`  out  CNT_W  saturating count of committed writes

## Operation
- **r0 (zero register):**
  - r0 always reads 0.
  - A write to r0 is discarded and not counted.
- **Write:** on a rising edge with `we`=1 and `wr_addr`≠0, `regs[wr_addr]` ← `wr_data`, and `wr_count` increments. `wr_count` saturates at 2^CNT_W−1.
- **Read bypass:** if `we`=1, `wr_addr`≠0, and `wr_addr` equals a read address, that read port returns `wr_data` in the same cycle (write-through). Otherwise it returns the stored value.
- **Simultaneous accesses:**
  - Both read ports may address the same register as the write; both are bypassed.
  - The debug capture follows the same bypass rule.
- **Debug FSM states and transitions:**
  - IDLE: when `dbg_req`=1, latch `dbg_addr` and go to CAPTURE.
  - CAPTURE: `dbg_data` ← register value (bypass applied; r0 gives 0), `dbg_ack` ← 1, go to DONE.
  - DONE: hold `dbg_ack`=1 and `dbg_data` stable. When `dbg_req`=0, clear `dbg_ack` and go to IDLE.
  - A request still high on re-entry to IDLE is not re-accepted. A new request needs `dbg_req` low for at least one cycle in IDLE.
- **Handshake rule:** the requester holds `dbg_req` and `dbg_addr` stable until `dbg_ack` rises. Changes to `dbg_addr` after acceptance are ignored.
- **Reset:**
  - Reset clears all registers, `wr_count`, `dbg_ack`, and `dbg_data` to 0, and puts the FSM in IDLE.
  - Reset mid-handshake returns to IDLE with `dbg_ack`=0 immediately; there is no pending response.

## Timing
- Read ports: zero-cycle combinational latency from address, and from `we`/`wr_addr`/`wr_data` through the bypass.
- Write: visible in storage one edge after `we`; visible at read ports in the same cycle through the bypass.
- Debug: `dbg_ack` rises on the 2nd edge after `dbg_req` is sampled high in IDLE. It falls one edge after `dbg_req` is sampled low in DONE.
- Write and debug activity are fully concurrent; debug never stalls the pipeline.
- Outputs after reset: `rs_data`/`rt_data` = 0 for any address until written; `dbg_ack`=0; `dbg_data`=0; `wr_count`=0.

## Structure
- Shared package `kgp_pkg`:
  - `REG_ZERO`=5'd0, `REG_RA`=5'd31, `DATA_W`, `ADDR_W`
  - debug FSM state encoding (IDLE, CAPTURE, DONE)
- Sub-module `kgp_regfile_dbg`: the debug FSM plus the address and data capture registers. It takes the selected bypassed read value as input; the storage array stays in `kgp_regfile`.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0; `wr_count`=0; `dbg_ack`=0.
- Write r5=0xDEADBEEF with `rs_addr`=5 in the same cycle → `rs_data`=0xDEADBEEF in that cycle; next cycle, with `we`=0, still 0xDEADBEEF; `wr_count`=1.
- Write r0=0xFFFFFFFF → r0 reads 0, `wr_count` unchanged.
- Link write via `wr_addr`=31, `wr_data`=0x00000040 → `rt_addr`=31 reads 0x40.
- Debug: r7=0x1234; raise `dbg_req` with `dbg_addr`=7 → `dbg_ack` rises 2 edges later with `dbg_data`=0x1234; hold `dbg_req` for 5 cycles → ack held; drop `dbg_req` → ack falls 1 edge later. Repeat while writing r7=0x5678 in the CAPTURE cycle → `dbg_data`=0x5678.
- Assert `rst_n`=0 while in DONE → `dbg_ack`=0 immediately, all registers 0. Separately, force `wr_count` to 0xFFFE and perform 3 writes → `wr_count` stays at 0xFFFF.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared constants and debug-port state encoding for the KGP-RISC register file.
package kgp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    DBG_IDLE    = 2'd0,
    DBG_CAPTURE = 2'd1,
    DBG_DONE    = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/kgp_regfile_dbg.sv
// Four-phase debug read port: latches the request address, captures the
// bypassed register value and holds it under dbg_ack until the request drops.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting; accepts a request only after seeing req low here
//   CAPTURE  | latched address is presented to the array, data sampled next
//   DONE     | ack and data held until the requester drops req
module kgp_regfile_dbg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_val,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              ack,
  output logic [DATA_W-1:0] data
);
  import kgp_pkg::*;

  dbg_state_t state;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DBG_IDLE;
      armed    <= 1'b1;
      sel_addr <= '0;
      ack      <= 1'b0;
      data     <= '0;
    end else begin
      case (state)
        DBG_IDLE: begin
          if (!req) begin
            armed <= 1'b1;
          end else if (armed) begin
            sel_addr <= addr;
            state    <= DBG_CAPTURE;
          end
        end
        DBG_CAPTURE: begin
          data  <= rd_val;
          ack   <= 1'b1;
          state <= DBG_DONE;
        end
        DBG_DONE: begin
          // Disarm so a request left high across re-entry is not taken twice.
          if (!req) begin
            ack   <= 1'b0;
            armed <= 1'b0;
            state <= DBG_IDLE;
          end
        end
        default: state <= DBG_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kgp_regfile.sv
// KGP-RISC general-purpose register file: 32 x 32 storage, two write-through
// read ports, one write port, a debug read port and a committed-write counter.
module kgp_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);
  import kgp_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  wr_cnt;
  logic              wr_hit;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_val;

  assign wr_hit = we && (wr_addr != ZERO_A);

  // Write-through: a same-cycle write to the addressed register wins over storage.
  assign rs_data = (wr_hit && wr_addr == rs_addr) ? wr_data :
                   (rs_addr == ZERO_A) ? '0 : regs[rs_addr];
  assign rt_data = (wr_hit && wr_addr == rt_addr) ? wr_data :
                   (rt_addr == ZERO_A) ? '0 : regs[rt_addr];
  assign dbg_val = (wr_hit && wr_addr == dbg_sel) ? wr_data :
                   (dbg_sel == ZERO_A) ? '0 : regs[dbg_sel];

  assign wr_count = wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
      if (wr_cnt != '1) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  kgp_regfile_dbg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (dbg_req),
    .addr     (dbg_addr),
    .rd_val   (dbg_val),
    .sel_addr (dbg_sel),
    .ack      (dbg_ack),
    .data     (dbg_data)
  );

endmodule
